rv32e_data_mem: RTL and testbench

Word-addressed data memory responder for one rv32e CPU data port. It is the target end of the CPU's `mem_addr_bus` / `mem_write_data_bus` / `mem_write_signal` / `mem_read_data_bus` interface. It provides combinational read, edge-qualified single-shot write and an optional memory-mapped I/O window (cycle counter, output latch, fault counter). One instance sits beside each CPU core in the tangprimer multiprocessor top level.

---
 rtl/rv32e_mem_pkg.sv | 16 +
 rtl/rv32e_data_mem_if.sv | 24 ++
 rtl/rv32e_dmem_mmio.sv | 66 ++++++
 rtl/rv32e_data_mem.sv | 95 +++++++++
 tb/tb_rv32e_data_mem.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32e_mem_pkg.sv
// Shared constants for the rv32e data memory and its MMIO window.
// Register offsets are byte offsets from IO_BASE.
package rv32e_mem_pkg;

  localparam logic [31:0] IO_BASE   = 32'hFFFF_FFF0;
  localparam logic [3:0]  IO_CYCLES = 4'h0;
  localparam logic [3:0]  IO_OUT    = 4'h4;
  localparam logic [3:0]  IO_FAULTS = 4'h8;

  function automatic int unsigned idx_width(
    input int unsigned depth
  );
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rv32e_data_mem_if.sv
// CPU data-port bus between one rv32e core (master) and its
// data memory (slave).
interface rv32e_data_mem_if;

  logic [31:0] mem_addr_bus;
  logic [31:0] mem_write_data_bus;
  logic        mem_write_signal;
  logic [31:0] mem_read_data_bus;

  modport master (
    output mem_addr_bus,
    output mem_write_data_bus,
    output mem_write_signal,
    input  mem_read_data_bus
  );

  modport slave (
    input  mem_addr_bus,
    input  mem_write_data_bus,
    input  mem_write_signal,
    output mem_read_data_bus
  );

endinterface

// File: rtl/rv32e_dmem_mmio.sv
// MMIO window: CYCLES counter, OUT latch, saturating FAULTS count.
// Only instantiated when RV32E_DMEM_IO_EN is defined.
module rv32e_dmem_mmio
  import rv32e_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] word_addr,
  input  logic [31:0] wdata,
  input  logic        wr_fire,
  input  logic        oor_wr,
  output logic        hit,
  output logic [31:0] rdata,
  output logic [31:0] io_out,
  output logic        fault_clr
);

  logic [3:0]  off;
  logic        is_cyc;
  logic        is_out;
  logic        is_flt;
  logic [31:0] cycles;
  logic [31:0] out_q;
  logic [31:0] faults;

  assign off = {word_addr[1:0], 2'b00};
  assign hit = (word_addr[29:2] == IO_BASE[31:4])
             && (is_cyc || is_out || is_flt);

  assign is_cyc = (off == IO_CYCLES);
  assign is_out = (off == IO_OUT);
  assign is_flt = (off == IO_FAULTS);

  assign fault_clr = wr_fire && hit && is_flt;
  assign io_out    = out_q;

  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (1'b1)
        is_cyc:  rdata = cycles;
        is_out:  rdata = out_q;
        is_flt:  rdata = faults;
        default: rdata = '0;
      endcase
    end
  end

  // Clearing FAULTS takes priority over a same-edge increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles <= '0;
      out_q  <= '0;
      faults <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (wr_fire && hit && is_out)
        out_q <= wdata;
      if (fault_clr)
        faults <= '0;
      else if (oor_wr && (faults != '1))
        faults <= faults + 32'd1;
    end
  end

endmodule

// File: rtl/rv32e_data_mem.sv
// Word-addressed data memory for one rv32e core; optional MMIO
// window enabled by defining RV32E_DMEM_IO_EN.
module rv32e_data_mem
  import rv32e_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  rv32e_data_mem_if.slave   bus,
  output logic [31:0]       io_out,
  output logic              fault
);

  localparam int unsigned AW = idx_width(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0] index;
  logic        in_range;
  logic        wr_q;
  logic        wr_fire;
  logic        wr_ok;
  logic        oor_wr;
  logic        io_hit;
  logic        fault_clr;
  logic [31:0] io_rdata;
  logic [31:0] rdata;
  logic        unused_addr_lsb;

  assign index    = bus.mem_addr_bus[31:2];
  assign in_range = (index < 30'(DEPTH_WORDS));
  assign unused_addr_lsb = ^bus.mem_addr_bus[1:0];

  // One write per rising level of mem_write_signal.
  assign wr_fire = bus.mem_write_signal & ~wr_q;
  assign wr_ok   = reset & wr_fire;
  assign oor_wr  = wr_fire & ~in_range & ~io_hit;

`ifdef RV32E_DMEM_IO_EN
  rv32e_dmem_mmio u_mmio (
    .clk       (clk),
    .reset     (reset),
    .word_addr (index),
    .wdata     (bus.mem_write_data_bus),
    .wr_fire   (wr_fire),
    .oor_wr    (oor_wr),
    .hit       (io_hit),
    .rdata     (io_rdata),
    .io_out    (io_out),
    .fault_clr (fault_clr)
  );
`else
  assign io_hit    = 1'b0;
  assign io_rdata  = '0;
  assign io_out    = '0;
  assign fault_clr = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wr_q <= 1'b0;
    else
      wr_q <= bus.mem_write_signal;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      fault <= 1'b0;
    else if (fault_clr)
      fault <= 1'b0;
    else if (oor_wr)
      fault <= 1'b1;
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok && in_range)
      mem[index[AW-1:0]] <= bus.mem_write_data_bus;
  end

  always_comb begin
    rdata = '0;
    if (!reset)
      rdata = '0;
    else if (in_range)
      rdata = mem[index[AW-1:0]];
    else if (io_hit)
      rdata = io_rdata;
  end

  assign bus.mem_read_data_bus = rdata;

endmodule

// File: tb/tb_rv32e_data_mem.sv
// Bench for rv32e_data_mem: vector table plus hand sequences for
// held writes, reset, and (RV32E_DMEM_IO_EN) the MMIO window.
module tb_rv32e_data_mem;

  logic        clk;
  logic        reset;
  logic [31:0] io_out;
  logic        fault;

  rv32e_data_mem_if bus();

  rv32e_data_mem #(
    .DEPTH_WORDS (1024),
    .INIT_FILE   ("")
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .io_out (io_out),
    .fault  (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
  } vec_t;

  vec_t vecs[9];

`ifdef RV32E_DMEM_IO_EN
  int unsigned cyc_model;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc_model <= 0;
    else        cyc_model <= cyc_model + 1;
  end
`endif

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_empty: got %h expected queued entry", act);
    end else begin
      e = sb.pop_front();
      chk(e.name, act, e.val);
    end
  endtask

  // One-cycle store pulse, then drop the level on the next negedge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.mem_addr_bus       = a;
    bus.mem_write_data_bus = d;
    bus.mem_write_signal   = 1'b1;
    @(negedge clk);
    bus.mem_write_signal   = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] a);
    bus.mem_addr_bus = a;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c1;
    c1 = '0;

    vecs = '{
      '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0},
      '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0},
      '{1'b1, 32'h0000_0014, 32'h1234_5678, 32'h1234_5678, 1'b0},
      '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0},
      '{1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b0},
      '{1'b1, 32'h0000_1000, 32'h0000_CAFE, 32'h0,         1'b1},
      '{1'b0, 32'h0000_0FFC, 32'h0,         32'hA5A5_A5A5, 1'b1},
      '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1},
      '{1'b0, 32'h0000_0014, 32'h0,         32'h1234_5678, 1'b1}
    };

    reset                  = 1'b0;
    bus.mem_addr_bus       = 32'h10;
    bus.mem_write_data_bus = '0;
    bus.mem_write_signal   = 1'b0;
    #3;
    chk("rst_rdata", bus.mem_read_data_bus, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_io_out", io_out, 32'h0);

    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.mem_addr_bus       = vecs[i].addr;
      bus.mem_write_data_bus = vecs[i].wdata;
      bus.mem_write_signal   = vecs[i].we;
      push($sformatf("vec%0d_rdata", i), vecs[i].rdata);
      push($sformatf("vec%0d_fault", i), {31'b0, vecs[i].fault});
      @(negedge clk);
      bus.mem_write_signal = 1'b0;
      #1;
      pop_chk(bus.mem_read_data_bus);
      pop_chk({31'b0, fault});
    end

    // Level held for three cycles with changing data.
    @(negedge clk);
    bus.mem_addr_bus       = 32'h20;
    bus.mem_write_data_bus = 32'd1;
    bus.mem_write_signal   = 1'b1;
    @(negedge clk);
    bus.mem_write_data_bus = 32'd2;
    @(negedge clk);
    bus.mem_write_data_bus = 32'd3;
    @(negedge clk);
    bus.mem_write_signal   = 1'b0;
    push("held_single", 32'd1);
    #1;
    pop_chk(bus.mem_read_data_bus);

    store(32'h20, 32'd9);
    push("second_pulse", 32'd9);
    pop_chk(bus.mem_read_data_bus);

    // New data visible only after the commit edge.
    @(negedge clk);
    bus.mem_addr_bus       = 32'h20;
    bus.mem_write_data_bus = 32'h55;
    bus.mem_write_signal   = 1'b1;
    #1;
    chk("raw_before", bus.mem_read_data_bus, 32'd9);
    @(posedge clk);
    #1;
    chk("raw_after", bus.mem_read_data_bus, 32'h55);
    @(negedge clk);
    bus.mem_write_signal = 1'b0;

`ifdef RV32E_DMEM_IO_EN
    look(32'hFFFF_FFF8);
    chk("faults_one", bus.mem_read_data_bus, 32'd1);

    look(32'hFFFF_FFF0);
    chk("cycles_abs", bus.mem_read_data_bus, cyc_model);
    c1 = bus.mem_read_data_bus;
    repeat (7) @(negedge clk);
    #1;
    chk("cycles_delta7", bus.mem_read_data_bus - c1, 32'd7);

    store(32'hFFFF_FFF0, 32'h1234);
    chk("cyc_wr_ignored", bus.mem_read_data_bus, cyc_model);
    chk("cyc_wr_nofault", {31'b0, fault}, 32'h1);

    @(negedge clk);
    bus.mem_addr_bus       = 32'hFFFF_FFF4;
    bus.mem_write_data_bus = 32'h5A;
    bus.mem_write_signal   = 1'b1;
    #1;
    chk("io_out_pre", io_out, 32'h0);
    @(posedge clk);
    #1;
    chk("io_out_post", io_out, 32'h5A);
    @(negedge clk);
    bus.mem_write_signal = 1'b0;
    #1;
    chk("out_read", bus.mem_read_data_bus, 32'h5A);

    store(32'hFFFF_FFF8, 32'h0);
    chk("faults_clr_flag", {31'b0, fault}, 32'h0);
    chk("faults_clr_cnt", bus.mem_read_data_bus, 32'h0);

    store(32'hFFFF_FFFC, 32'h1);
    chk("beyond_win_fault", {31'b0, fault}, 32'h1);
    chk("beyond_win_rd", bus.mem_read_data_bus, 32'h0);
    look(32'hFFFF_FFF8);
    chk("faults_again", bus.mem_read_data_bus, 32'd1);
`endif

    // Async reset between edges, store held across release.
    @(negedge clk);
    bus.mem_addr_bus = 32'h10;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_rdata", bus.mem_read_data_bus, 32'h0);
    chk("arst_fault", {31'b0, fault}, 32'h0);
    chk("arst_io_out", io_out, 32'h0);
    bus.mem_addr_bus       = 32'h30;
    bus.mem_write_data_bus = 32'h77;
    bus.mem_write_signal   = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_store", bus.mem_read_data_bus, 32'h77);
    @(negedge clk);
    bus.mem_write_signal = 1'b0;
    look(32'h10);
    chk("retained_0x10", bus.mem_read_data_bus, 32'hDEAD_BEEF);
    look(32'h20);
    chk("retained_0x20", bus.mem_read_data_bus, 32'h55);

`ifdef RV32E_DMEM_IO_EN
    look(32'hFFFF_FFF0);
    chk("cycles_after_rst", bus.mem_read_data_bus, cyc_model);
`else
    store(32'hFFFF_FFF4, 32'h5A);
    chk("off_fault", {31'b0, fault}, 32'h1);
    chk("off_io_out", io_out, 32'h0);
    chk("off_rdata", bus.mem_read_data_bus, 32'h0);
`endif

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries expected 0",
               sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
